dae_frame_serializer: RTL and testbench

Downstream neighbour of the DAE decoder. Captures each 4-sample denoised frame (output0..output3) on a strobe into a small frame FIFO. Replays the samples one at a time at a fixed sample rate, derived from a clock divider, over a valid/ready stream to the DAC/I2S transmitter. Counts dropped frames (FIFO full) and output underruns for debug.

---
 rtl/dae_frame_serializer.sv | 195 +++++++++++++++++++
 tb/tb_dae_frame_serializer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dae_frame_serializer.sv
// Buffers 4-sample DAE decoder frames in a small FIFO and replays them one sample per divider slot.
// Optional OUT_SAT_GAIN_EN adds a gain_sh port: saturating left shift applied when a sample is loaded.

module dae_frame_serializer #(
   parameter int unsigned DW       = 8,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned TICK_DIV = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in0,
   input  logic [DW-1:0] in1,
   input  logic [DW-1:0] in2,
   input  logic [DW-1:0] in3,
`ifdef OUT_SAT_GAIN_EN
   input  logic [1:0]    gain_sh,
`endif
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_sample,
   output logic          out_last,
   output logic [7:0]    drop_cnt,
   output logic [7:0]    underrun_cnt
);

   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW   = $clog2(DEPTH + 1);
   localparam int unsigned DIVW = $clog2(TICK_DIV);
   localparam int unsigned FW   = 4 * DW;

   typedef enum logic {ST_WAIT, ST_SEND} state_t;

   state_t          state_q, state_d;
   logic [DIVW-1:0] div_q, div_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [1:0]      idx_q, idx_d;
   logic            started_q, started_d;
   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   out_sample_q, out_sample_d;
   logic            out_last_q, out_last_d;
   logic            in_ready_q, in_ready_d;
   logic [7:0]      drop_q, drop_d;
   logic [7:0]      under_q, under_d;

   logic [FW-1:0]   mem_q [DEPTH];
   logic [FW-1:0]   frame_c;
   logic [DW-1:0]   head_c;
   logic [DW-1:0]   load_c;
   logic            slot_c, full_c, empty_c, hs_c, pop_c, push_c;

   assign slot_c  = (div_q == DIVW'(TICK_DIV - 1));
   assign full_c  = (count_q == CW'(DEPTH));
   assign empty_c = (count_q == '0);
   assign hs_c    = (state_q == ST_SEND) && out_ready;
   assign pop_c   = hs_c && (idx_q == 2'd3);
   assign push_c  = in_valid && (!full_c || pop_c);

   // Frame storage; in0 sits in the low lane and leaves first.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= {in3, in2, in1, in0};
      end
   end

   always_comb begin
      frame_c = mem_q[rd_ptr_q];
      case (idx_q)
         2'd0:    head_c = frame_c[DW-1:0];
         2'd1:    head_c = frame_c[2*DW-1:DW];
         2'd2:    head_c = frame_c[3*DW-1:2*DW];
         default: head_c = frame_c[4*DW-1:3*DW];
      endcase
   end

`ifdef OUT_SAT_GAIN_EN
   localparam int unsigned GW = DW + 3;
   logic signed [GW-1:0] wide_c, max_c, min_c;

   // Three guard bits cover the largest shift before clamping to the DW range.
   always_comb begin
      wide_c = $signed({{3{head_c[DW-1]}}, head_c}) <<< gain_sh;
      max_c  = GW'((2 ** (DW - 1)) - 1);
      min_c  = ~max_c;
      if (wide_c > max_c) begin
         load_c = max_c[DW-1:0];
      end else if (wide_c < min_c) begin
         load_c = min_c[DW-1:0];
      end else begin
         load_c = wide_c[DW-1:0];
      end
   end
`else
   assign load_c = head_c;
`endif

   // Next-state: divider, FIFO bookkeeping, counters and the WAIT/SEND sequencer.
   always_comb begin
      state_d      = state_q;
      div_d        = slot_c ? '0 : div_q + DIVW'(1);
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      idx_d        = idx_q;
      started_d    = started_q | push_c;
      out_valid_d  = out_valid_q;
      out_sample_d = out_sample_q;
      out_last_d   = out_last_q;
      drop_d       = drop_q;
      under_d      = under_q;

      if (push_c) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      in_ready_d = (count_d != CW'(DEPTH));

      if (in_valid && full_c && !pop_c && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end

      case (state_q)
         ST_WAIT: begin
            if (slot_c) begin
               if ((idx_q != 2'd0) || !empty_c) begin
                  state_d      = ST_SEND;
                  out_valid_d  = 1'b1;
                  out_sample_d = load_c;
                  out_last_d   = (idx_q == 2'd3);
               end else if (started_q && (under_q != 8'hFF)) begin
                  under_d = under_q + 8'd1;
               end
            end
         end
         default: begin
            // A slot seen while still holding a sample is simply skipped.
            if (out_ready) begin
               state_d     = ST_WAIT;
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               idx_d       = idx_q + 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_WAIT;
         div_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         idx_q        <= 2'd0;
         started_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_sample_q <= '0;
         out_last_q   <= 1'b0;
         in_ready_q   <= 1'b1;
         drop_q       <= 8'd0;
         under_q      <= 8'd0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         idx_q        <= idx_d;
         started_q    <= started_d;
         out_valid_q  <= out_valid_d;
         out_sample_q <= out_sample_d;
         out_last_q   <= out_last_d;
         in_ready_q   <= in_ready_d;
         drop_q       <= drop_d;
         under_q      <= under_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_sample   = out_sample_q;
   assign out_last     = out_last_q;
   assign drop_cnt     = drop_q;
   assign underrun_cnt = under_q;

endmodule

// File: tb/tb_dae_frame_serializer.sv
// Self-checking bench for dae_frame_serializer: directed scenarios plus random traffic against a queue-based model.
// Build with OUT_SAT_GAIN_EN defined to also exercise the gain port.

module tb_dae_frame_serializer;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned TD    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
   logic [1:0]    gain_sh = 2'd0;
   logic          in_ready, out_valid, out_last;
   logic [DW-1:0] out_sample;
   logic [7:0]    drop_cnt, underrun_cnt;

   always #5 clk = ~clk;

   dae_frame_serializer #(.DW(DW), .DEPTH(DEPTH), .TICK_DIV(TD)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in0          (in0),
      .in1          (in1),
      .in2          (in2),
      .in3          (in3),
`ifdef OUT_SAT_GAIN_EN
      .gain_sh      (gain_sh),
`endif
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sample   (out_sample),
      .out_last     (out_last),
      .drop_cnt     (drop_cnt),
      .underrun_cnt (underrun_cnt)
   );

   int n_checks = 0, n_errors = 0;
   int mon_checks = 0, mon_errors = 0;
   int edges = 0;

   // Reference model: queue of whole frames, a sample index and slot timing from the edge count.
   logic [4*DW-1:0] m_q[$];
   int              m_cyc, m_idx, m_drop, m_under;
   bit              m_valid, m_last, m_started, m_ready;
   logic [DW-1:0]   m_sample;

   function automatic logic [DW-1:0] scale(input logic [4*DW-1:0] f, input int i, input int g);
      logic [DW-1:0] s;
      int            v;
      s = f[i*DW +: DW];
      v = $signed(s);
      v = v * (2 ** g);
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      return DW'(v);
   endfunction

   task automatic model_step();
      int  size0;
      bit  slot, pop, do_push;
      int  g;
`ifdef OUT_SAT_GAIN_EN
      g = int'(gain_sh);
`else
      g = 0;
`endif
      if (!rst_n) begin
         m_q.delete();
         m_cyc = 0; m_idx = 0; m_drop = 0; m_under = 0;
         m_valid = 0; m_last = 0; m_started = 0; m_ready = 1; m_sample = '0;
      end else begin
         size0   = m_q.size();
         slot    = (m_cyc % TD) == (TD - 1);
         pop     = m_valid && out_ready && (m_idx == 3);
         do_push = in_valid && ((size0 < DEPTH) || pop);
         if (in_valid && !do_push && m_drop < 255) m_drop++;
         if (m_valid) begin
            if (out_ready) begin
               m_valid = 0;
               if (m_idx == 3) begin
                  void'(m_q.pop_front());
                  m_idx = 0;
               end else begin
                  m_idx++;
               end
            end
         end else if (slot) begin
            if (m_idx != 0 || size0 > 0) begin
               m_valid  = 1;
               m_sample = scale(m_q[0], m_idx, g);
               m_last   = (m_idx == 3);
            end else if (m_started && m_under < 255) begin
               m_under++;
            end
         end
         if (do_push) begin
            m_q.push_back({in3, in2, in1, in0});
            m_started = 1;
         end
         m_ready = m_q.size() < DEPTH;
         m_cyc++;
      end
   endtask

   always @(posedge clk or negedge rst_n) model_step();

   task automatic mon_cmp();
      if (!rst_n) return;
      mon_checks++;
      if (out_valid !== m_valid) begin
         mon_errors++;
         $display("FAIL mon_out_valid t=%0t actual=%b expected=%b", $time, out_valid, m_valid);
      end
      mon_checks++;
      if (in_ready !== m_ready) begin
         mon_errors++;
         $display("FAIL mon_in_ready t=%0t actual=%b expected=%b", $time, in_ready, m_ready);
      end
      mon_checks++;
      if (drop_cnt !== 8'(m_drop)) begin
         mon_errors++;
         $display("FAIL mon_drop_cnt t=%0t actual=%0d expected=%0d", $time, drop_cnt, m_drop);
      end
      mon_checks++;
      if (underrun_cnt !== 8'(m_under)) begin
         mon_errors++;
         $display("FAIL mon_underrun_cnt t=%0t actual=%0d expected=%0d", $time, underrun_cnt, m_under);
      end
      if (m_valid) begin
         mon_checks++;
         if (out_sample !== m_sample || out_last !== m_last) begin
            mon_errors++;
            $display("FAIL mon_sample t=%0t actual=%0d/%b expected=%0d/%b", $time,
                     $signed(out_sample), out_last, $signed(m_sample), m_last);
         end
      end
   endtask

   always @(negedge clk) mon_cmp();

   task automatic tick();
      @(posedge clk);
      #1;
      edges++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      edges = 0;
   endtask

   task automatic push_vec(input logic [4*DW-1:0] f);
      {in3, in2, in1, in0} = f;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Advances until out_valid is seen; ok stays 0 if the budget runs out.
   task automatic wait_valid(input int budget, output bit ok);
      ok = 0;
      for (int k = 0; k < budget; k++) begin
         if (out_valid) begin
            ok = 1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, out_last, in_ready, out_sample, drop_cnt, underrun_cnt} !== {3'b001, 24'd0}) begin
         n_errors++;
         $display("FAIL reset_state actual=%b%b%b %0d %0d %0d expected=001 0 0 0",
                  out_valid, out_last, in_ready, out_sample, drop_cnt, underrun_cnt);
      end
   endtask

   task automatic test_single_frame();
      logic [DW-1:0] exp_s [4];
      logic [DW-1:0] got_s [4];
      bit            got_l [4];
      int            got_t [4];
      int            n;
      exp_s[0] = 8'(10); exp_s[1] = 8'(-20); exp_s[2] = 8'(30); exp_s[3] = 8'(-40);
      do_reset();
      out_ready = 1'b1;
      tick();
      push_vec({exp_s[3], exp_s[2], exp_s[1], exp_s[0]});
      n = 0;
      for (int c = 0; c < 80 && n < 4; c++) begin
         if (out_valid) begin
            got_s[n] = out_sample; got_l[n] = out_last; got_t[n] = edges;
            n++;
         end
         tick();
      end
      n_checks++;
      if (n != 4) begin
         n_errors++;
         $display("FAIL single_count actual=%0d expected=4", n);
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (got_s[k] !== exp_s[k] || got_l[k] !== (k == 3) || got_t[k] != 4 + 4 * k) begin
               n_errors++;
               $display("FAIL single_sample%0d actual=%0d last=%b edge=%0d expected=%0d last=%b edge=%0d",
                        k, $signed(got_s[k]), got_l[k], got_t[k], $signed(exp_s[k]), k == 3, 4 + 4 * k);
            end
         end
      end
      n_checks++;
      if (drop_cnt !== 8'd0) begin
         n_errors++;
         $display("FAIL single_drop actual=%0d expected=0", drop_cnt);
      end
   endtask

   task automatic test_drop();
      logic [4*DW-1:0] f [3];
      logic [DW-1:0]   e;
      int              n;
      do_reset();
      for (int k = 0; k < 3; k++) f[k] = {$urandom, $urandom} & {4*DW{1'b1}};
      for (int k = 0; k < 3; k++) push_vec(f[k]);
      tick();
      n_checks++;
      if (drop_cnt !== 8'd1 || in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL drop_third actual=%0d/%b expected=1/0", drop_cnt, in_ready);
      end
      out_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 200 && n < 8; c++) begin
         if (out_valid) begin
            e = f[n / 4][(n % 4) * DW +: DW];
            n_checks++;
            if (out_sample !== e) begin
               n_errors++;
               $display("FAIL drop_order%0d actual=%0d expected=%0d", n, $signed(out_sample), $signed(e));
            end
            n++;
         end
         tick();
      end
      n_checks++;
      if (n != 8) begin
         n_errors++;
         $display("FAIL drop_drain actual=%0d expected=8", n);
      end
      // Saturation of the drop counter.
      out_ready = 1'b0;
      for (int k = 0; k < 300; k++) push_vec(f[0]);
      n_checks++;
      if (drop_cnt !== 8'd255) begin
         n_errors++;
         $display("FAIL drop_saturate actual=%0d expected=255", drop_cnt);
      end
   endtask

   task automatic test_stall();
      logic [4*DW-1:0] f;
      bit              ok;
      int              h, exp_edge;
      do_reset();
      f = {$urandom} & {4*DW{1'b1}};
      out_ready = 1'b1;
      push_vec(f);
      wait_valid(40, ok);
      tick();
      out_ready = 1'b0;
      wait_valid(40, ok);
      n_checks++;
      if (!ok || out_sample !== f[DW +: DW]) begin
         n_errors++;
         $display("FAIL stall_sample1 actual=%b/%0d expected=1/%0d", ok, $signed(out_sample), $signed(f[DW +: DW]));
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_sample !== f[DW +: DW]) begin
            n_errors++;
            $display("FAIL stall_hold%0d actual=%b/%0d expected=1/%0d", k, out_valid, $signed(out_sample), $signed(f[DW +: DW]));
         end
      end
      out_ready = 1'b1;
      tick();
      h = edges;
      exp_edge = h + 1;
      while (exp_edge % TD != 0) exp_edge++;
      wait_valid(40, ok);
      n_checks++;
      if (!ok || edges != exp_edge || out_sample !== f[2*DW +: DW]) begin
         n_errors++;
         $display("FAIL stall_next actual=%b edge=%0d %0d expected=1 edge=%0d %0d",
                  ok, edges, $signed(out_sample), exp_edge, $signed(f[2*DW +: DW]));
      end
      tick();
      wait_valid(40, ok);
      n_checks++;
      if (!ok || out_sample !== f[3*DW +: DW] || out_last !== 1'b1) begin
         n_errors++;
         $display("FAIL stall_last actual=%b/%0d/%b expected=1/%0d/1", ok, $signed(out_sample), out_last, $signed(f[3*DW +: DW]));
      end
      tick();
   endtask

   task automatic test_underrun();
      bit ok;
      do_reset();
      out_ready = 1'b1;
      repeat (5 * TD) tick();
      n_checks++;
      if (underrun_cnt !== 8'd0) begin
         n_errors++;
         $display("FAIL underrun_idle actual=%0d expected=0", underrun_cnt);
      end
      push_vec({$urandom} & {4*DW{1'b1}});
      for (int k = 0; k < 4; k++) begin
         wait_valid(40, ok);
         if (k < 3) tick();
      end
      tick();
      repeat (3 * TD) tick();
      n_checks++;
      if (underrun_cnt !== 8'd3) begin
         n_errors++;
         $display("FAIL underrun_three actual=%0d expected=3", underrun_cnt);
      end
      repeat (300 * TD) tick();
      n_checks++;
      if (underrun_cnt !== 8'd255) begin
         n_errors++;
         $display("FAIL underrun_saturate actual=%0d expected=255", underrun_cnt);
      end
   endtask

   task automatic test_reset_mid();
      logic [4*DW-1:0] f, g;
      bit              ok;
      do_reset();
      f = {$urandom} & {4*DW{1'b1}};
      g = {$urandom} & {4*DW{1'b1}};
      for (int k = 0; k < 3; k++) push_vec(f);
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wait_valid(40, ok);
         tick();
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || drop_cnt !== 8'd0 || underrun_cnt !== 8'd0 || in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL midreset_state actual=%b %0d %0d %b expected=0 0 0 1", out_valid, drop_cnt, underrun_cnt, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      edges = 0;
      tick();
      push_vec(g);
      wait_valid(40, ok);
      n_checks++;
      if (!ok || out_sample !== g[DW-1:0] || out_last !== 1'b0) begin
         n_errors++;
         $display("FAIL midreset_restart actual=%b/%0d/%b expected=1/%0d/0", ok, $signed(out_sample), out_last, $signed(g[DW-1:0]));
      end
      repeat (4 * TD) tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 7) == 0);
         {in3, in2, in1, in0} = {$urandom} & {4*DW{1'b1}};
         out_ready = (c / 500) % 2 == 1 ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (20 * TD) tick();
   endtask

`ifdef OUT_SAT_GAIN_EN
   task automatic test_gain();
      logic [DW-1:0] e [4];
      bit            ok;
      e[0] = 8'(80); e[1] = 8'(127); e[2] = 8'(-128); e[3] = 8'(-80);
      do_reset();
      gain_sh = 2'd2;
      out_ready = 1'b1;
      push_vec({8'(-20), 8'(-40), 8'(40), 8'(20)});
      for (int k = 0; k < 4; k++) begin
         wait_valid(40, ok);
         n_checks++;
         if (!ok || out_sample !== e[k]) begin
            n_errors++;
            $display("FAIL gain_sample%0d actual=%0d expected=%0d", k, $signed(out_sample), $signed(e[k]));
         end
         tick();
      end
      gain_sh = 2'd0;
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_drop();
      test_stall();
      test_underrun();
      test_reset_mid();
`ifdef OUT_SAT_GAIN_EN
      test_gain();
`endif
      test_random();
      n_checks += mon_checks;
      n_errors += mon_errors;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
